// File: rtl/float_stream_acc_pkg.sv
// float_pkg: shared float field layout, zero constant and
// accumulator state encoding for the float stream accumulator.
package float_pkg;

    localparam int DEF_MANTISSA_SIZE = 23;
    localparam int DEF_EXPONENT_SIZE = 8;

    function automatic int float_size(input int e, input int m);
        return 1 + e + m;
    endfunction

    function automatic int sign_pos(input int e, input int m);
        return e + m;
    endfunction

    function automatic int exp_lsb(input int m);
        return m;
    endfunction

    localparam int FLOAT_SIZE =
        float_size(DEF_EXPONENT_SIZE, DEF_MANTISSA_SIZE);

    localparam logic [FLOAT_SIZE-1:0] FLOAT_ZERO = '0;

    typedef enum logic [2:0] {
        ACCUM,
        COLLECT,
        RED1,
        RED2,
        OUT
    } acc_state_e;

endpackage

// File: rtl/float_stream_acc_add.sv
// FloatAdd: 4-stage pipelined float adder, round-to-nearest-even.
// Stages: unpack/swap, align+add, normalize, round/pack.
module FloatAdd
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] a,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] b,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] y
);

    localparam int M  = MANTISSA_SIZE;
    localparam int E  = EXPONENT_SIZE;
    localparam int FS = float_size(E, M);
    localparam int SP = sign_pos(E, M);
    localparam int EL = exp_lsb(M);
    localparam logic [E-1:0]   EMAX = '1;
    localparam logic [E-1:0]   EONE = E'(1);
    localparam logic [M+3:0]   ONES = '1;

    logic          s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
    logic          s1_byp_q, s1_byp_d;
    logic [FS-1:0] s1_bv_q, s1_bv_d;
    logic [E-1:0]  s1_exp_q, s1_exp_d, s1_sh_q, s1_sh_d;
    logic [M:0]    s1_mb_q, s1_mb_d, s1_ms_q, s1_ms_d;

    logic          s2_sign_q, s2_sign_d, s2_byp_q, s2_byp_d;
    logic [FS-1:0] s2_bv_q, s2_bv_d;
    logic [E-1:0]  s2_exp_q, s2_exp_d;
    logic [M+4:0]  s2_sum_q, s2_sum_d;

    logic          s3_sign_q, s3_sign_d, s3_byp_q, s3_byp_d;
    logic [FS-1:0] s3_bv_q, s3_bv_d;
    logic [E:0]    s3_e_q, s3_e_d;
    logic [M+3:0]  s3_m_q, s3_m_d;

    logic [FS-1:0] y_q, y_d;

    logic          ge;
    logic [FS-1:0] big, sml;
    logic [E-1:0]  eb, es, ebe, ese;

    // Stage 1: order operands by magnitude, catch zero/inf/NaN bypass.
    always_comb begin
        ge  = a[SP-1:0] >= b[SP-1:0];
        big = ge ? a : b;
        sml = ge ? b : a;
        eb  = big[SP-1:EL];
        es  = sml[SP-1:EL];
        ebe = (eb == '0) ? EONE : eb;
        ese = (es == '0) ? EONE : es;
        s1_sign_d = big[SP];
        s1_sub_d  = a[SP] ^ b[SP];
        s1_exp_d  = ebe;
        s1_sh_d   = ebe - ese;
        s1_mb_d   = {eb != '0, big[M-1:0]};
        s1_ms_d   = {es != '0, sml[M-1:0]};
        s1_byp_d  = 1'b0;
        s1_bv_d   = big;
        if (eb == EMAX) begin
            s1_byp_d = 1'b1;
            if (es == EMAX && s1_sub_d)
                s1_bv_d = {1'b0, EMAX, {M{1'b0}}}
                        | (FS'(1) << (M - 1));
        end else if (sml[SP-1:0] == '0) begin
            s1_byp_d = 1'b1;
            if (big[SP-1:0] == '0)
                s1_bv_d = {big[SP] & sml[SP], {(FS-1){1'b0}}};
        end
    end

    logic [M+3:0] bx, sx, sa;
    logic         lost;

    // Stage 2: align the smaller significand with sticky, add or subtract.
    always_comb begin
        bx   = {s1_mb_q, 3'b000};
        sx   = {s1_ms_q, 3'b000};
        sa   = sx >> s1_sh_q;
        lost = |(sx & ~(ONES << s1_sh_q));
        sa   = {sa[M+3:1], sa[0] | lost};
        s2_sum_d  = s1_sub_q ? ({1'b0, bx} - {1'b0, sa})
                             : ({1'b0, bx} + {1'b0, sa});
        s2_sign_d = s1_sign_q;
        s2_exp_d  = s1_exp_q;
        s2_byp_d  = s1_byp_q;
        s2_bv_d   = s1_bv_q;
    end

    logic [E:0] lz, sh, emx;
    logic       found;

    // Stage 3: normalize; left shift stops at the subnormal floor.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = M + 3; i >= 0; i--) begin
            if (!found) begin
                if (s2_sum_q[i]) found = 1'b1;
                else lz = lz + (E+1)'(1);
            end
        end
        emx = {1'b0, s2_exp_q} - (E+1)'(1);
        sh  = (lz < emx) ? lz : emx;
        if (s2_sum_q[M+4]) begin
            s3_m_d = {s2_sum_q[M+4:2], |s2_sum_q[1:0]};
            s3_e_d = {1'b0, s2_exp_q} + (E+1)'(1);
        end else begin
            s3_m_d = s2_sum_q[M+3:0] << sh;
            s3_e_d = s3_m_d[M+3] ? ({1'b0, s2_exp_q} - sh) : '0;
        end
        s3_sign_d = s2_sign_q & (s2_sum_q != '0);
        s3_byp_d  = s2_byp_q;
        s3_bv_d   = s2_bv_q;
    end

    logic [M:0]   keep;
    logic         rup;
    logic [M+1:0] rnd;
    logic [E:0]   fe;
    logic [M-1:0] mant;

    // Stage 4: round to nearest even, saturate exponent to infinity.
    always_comb begin
        keep = s3_m_q[M+3:3];
        rup  = s3_m_q[2] & (s3_m_q[1] | s3_m_q[0] | keep[0]);
        rnd  = {1'b0, keep} + {{(M+1){1'b0}}, rup};
        fe   = s3_e_q + {{E{1'b0}}, rnd[M+1]};
        if (s3_e_q == '0 && rnd[M]) fe = (E+1)'(1);
        mant = rnd[M+1] ? rnd[M:1] : rnd[M-1:0];
        if (s3_byp_q)
            y_d = s3_bv_q;
        else if (fe >= {1'b0, EMAX})
            y_d = {s3_sign_q, EMAX, {M{1'b0}}};
        else
            y_d = {s3_sign_q, fe[E-1:0], mant};
    end

    // Pipeline registers for all four stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_byp_q <= 1'b0;
            s1_bv_q   <= '0;   s1_exp_q <= '0;   s1_sh_q  <= '0;
            s1_mb_q   <= '0;   s1_ms_q  <= '0;
            s2_sign_q <= 1'b0; s2_byp_q <= 1'b0; s2_bv_q  <= '0;
            s2_exp_q  <= '0;   s2_sum_q <= '0;
            s3_sign_q <= 1'b0; s3_byp_q <= 1'b0; s3_bv_q  <= '0;
            s3_e_q    <= '0;   s3_m_q   <= '0;
            y_q       <= '0;
        end else begin
            s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d;
            s1_byp_q  <= s1_byp_d;  s1_bv_q  <= s1_bv_d;
            s1_exp_q  <= s1_exp_d;  s1_sh_q  <= s1_sh_d;
            s1_mb_q   <= s1_mb_d;   s1_ms_q  <= s1_ms_d;
            s2_sign_q <= s2_sign_d; s2_byp_q <= s2_byp_d;
            s2_bv_q   <= s2_bv_d;   s2_exp_q <= s2_exp_d;
            s2_sum_q  <= s2_sum_d;
            s3_sign_q <= s3_sign_d; s3_byp_q <= s3_byp_d;
            s3_bv_q   <= s3_bv_d;   s3_e_q   <= s3_e_d;
            s3_m_q    <= s3_m_d;
            y_q       <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/float_stream_acc.sv
// float_stream_acc: streaming float sum over ADD_LATENCY interleaved lanes.
// Option macro FLOAT_STREAM_ACC_SUBNORMAL_FLUSH_EN flushes subnormal inputs.
module float_stream_acc
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int ADD_LATENCY   = 4
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 inValid,
    output logic                                 inReady,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] inData,
    input  logic                                 inLast,
    output logic                                 outValid,
    input  logic                                 outReady,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] outData,
    output logic [15:0]                          outCount
);

    localparam int FS    = float_size(EXPONENT_SIZE, MANTISSA_SIZE);
    localparam int LANES = ADD_LATENCY;
    localparam logic [FS-1:0] ZERO = FS'(FLOAT_ZERO);

    acc_state_e      state_q, state_d;
    logic [LANES-1:0] lane_q, lane_d;
    logic [FS-1:0]   r_q [LANES];
    logic [FS-1:0]   r_d [LANES];
    logic [FS-1:0]   s0_q, s0_d, s1_q, s1_d, out_q, out_d;
    logic [15:0]     count_q, count_d;
    logic [3:0]      step_q, step_d;
    logic            xfer;
    logic [FS-1:0]   in_f, add_a, add_b, add_y;

`ifdef FLOAT_STREAM_ACC_SUBNORMAL_FLUSH_EN
    localparam int SP = sign_pos(EXPONENT_SIZE, MANTISSA_SIZE);
    localparam int EL = exp_lsb(MANTISSA_SIZE);
    assign in_f = (inData[SP-1:EL] == '0) ? ZERO : inData;
`else
    assign in_f = inData;
`endif

    assign inReady  = (state_q == ACCUM);
    assign outValid = (state_q == OUT);
    assign outData  = out_q;
    assign outCount = count_q;
    assign xfer     = inValid && inReady;

    FloatAdd #(
        .MANTISSA_SIZE(MANTISSA_SIZE),
        .EXPONENT_SIZE(EXPONENT_SIZE)
    ) u_add (
        .clk    (clk),
        .resetn (resetn),
        .a      (add_a),
        .b      (add_b),
        .y      (add_y)
    );

    // Next state, adder operand steering and lane/result bookkeeping.
    always_comb begin
        state_d = state_q;
        lane_d  = {lane_q[LANES-2:0], 1'b0};
        r_d     = r_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        out_d   = out_q;
        count_d = count_q;
        step_d  = step_q + 4'd1;
        add_a   = ZERO;
        add_b   = ZERO;
        unique case (state_q)
            ACCUM: begin
                step_d = '0;
                if (xfer) add_a = in_f;
                if (lane_q[LANES-1]) add_b = add_y;
                lane_d = {lane_q[LANES-2:0], xfer | lane_q[LANES-1]};
                if (xfer && count_q != 16'hFFFF)
                    count_d = count_q + 16'd1;
                if (xfer && inLast) state_d = COLLECT;
            end
            COLLECT: begin
                r_d[step_q[1:0]] = lane_q[LANES-1] ? add_y : ZERO;
                if (step_q == 4'd3) state_d = RED1;
            end
            RED1: begin
                if (step_q == 4'd4) begin
                    add_a = r_q[0];
                    add_b = r_q[1];
                end
                if (step_q == 4'd5) begin
                    add_a = r_q[2];
                    add_b = r_q[3];
                end
                if (step_q == 4'd8) s0_d = add_y;
                if (step_q == 4'd9) s1_d = add_y;
                if (step_q == 4'd10) state_d = RED2;
            end
            RED2: begin
                // issue at step 11 so the sum lands on the 16th edge
                if (step_q == 4'd11) begin
                    add_a = s0_q;
                    add_b = s1_q;
                end
                if (step_q == 4'd15) begin
                    out_d   = add_y;
                    state_d = OUT;
                end
            end
            OUT: begin
                step_d = '0;
                if (outReady) begin
                    state_d = ACCUM;
                    lane_d  = '0;
                    count_d = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ACCUM;
            lane_q  <= '0;
            r_q     <= '{default: '0};
            s0_q    <= '0;
            s1_q    <= '0;
            out_q   <= '0;
            count_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            r_q     <= r_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            out_q   <= out_d;
            count_q <= count_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_float_stream_acc.sv
// tb_float_stream_acc: directed streams with hand-computed sums,
// latency, backpressure hold and mid-stream reset checks.
module tb_float_stream_acc;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inValid = 1'b0;
    logic        inLast = 1'b0;
    logic        outReady = 1'b0;
    logic [31:0] inData = '0;
    logic        inReady, outValid;
    logic [31:0] outData;
    logic [15:0] outCount;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] vec [$];

    always #5 clk = ~clk;

    float_stream_acc dut (
        .clk      (clk),
        .resetn   (resetn),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .inLast   (inLast),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outCount (outCount)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        int n = 0;
        inValid = 1'b1;
        inData  = d;
        inLast  = last;
        while (!inReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        inValid = 1'b0;
        inLast  = 1'b0;
        inData  = '0;
    endtask

    task automatic pop(input string tag);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        check({tag, "_pop_valid"}, {31'd0, outValid}, 32'd0);
        check({tag, "_pop_ready"}, {31'd0, inReady}, 32'd1);
        check({tag, "_pop_count"}, {16'd0, outCount}, 32'd0);
    endtask

    task automatic run_stream(input string tag, input int idle,
                              input logic [31:0] exp_d,
                              input logic [31:0] exp_n);
        int lat = 0;
        for (int i = 0; i < vec.size(); i++) begin
            push(vec[i], i == vec.size() - 1);
            if (i != vec.size() - 1)
                repeat (idle) begin @(posedge clk); #1; end
        end
        while (!outValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 32'd16);
        check({tag, "_data"}, outData, exp_d);
        check({tag, "_count"}, {16'd0, outCount}, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, inReady}, 32'd1);
        check("rst_valid", {31'd0, outValid}, 32'd0);
        check("rst_data", outData, 32'd0);
        check("rst_count", {16'd0, outCount}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        vec = {};
        vec.push_back(32'h3F800000);
        run_stream("single", 0, 32'h3F800000, 32'd1);
        pop("single");

        vec = {};
        repeat (8) vec.push_back(32'h3F800000);
        run_stream("eight", 0, 32'h41000000, 32'd8);
        pop("eight");

        vec = {};
        repeat (3) vec.push_back(32'h40000000);
        run_stream("idle", 5, 32'h40C00000, 32'd3);
        pop("idle");

        vec = {};
        vec.push_back(32'h40A00000);
        vec.push_back(32'hC0A00000);
        vec.push_back(32'h40400000);
        run_stream("cancel", 0, 32'h40400000, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_data", outData, 32'h40400000);
            check("hold_count", {16'd0, outCount}, 32'd3);
            check("hold_ready", {31'd0, inReady}, 32'd0);
            check("hold_valid", {31'd0, outValid}, 32'd1);
        end
        pop("cancel");

        vec = {};
        vec.push_back(32'h3FC00000);
        vec.push_back(32'h3E800000);
        run_stream("frac", 0, 32'h3FE00000, 32'd2);
        pop("frac");

        push(32'h3F800000, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", {31'd0, inReady}, 32'd0);
        resetn = 1'b0;
        #2;
        check("mid_rst_ready", {31'd0, inReady}, 32'd1);
        check("mid_rst_valid", {31'd0, outValid}, 32'd0);
        check("mid_rst_count", {16'd0, outCount}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        vec = {};
        vec.push_back(32'h3F800000);
        vec.push_back(32'h40000000);
        run_stream("after_rst", 0, 32'h40400000, 32'd2);
        pop("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
